nonrestoring_div_32: RTL and testbench

//  Sequential signed 32/32 divider, the DIV counterpart to the Booth multiplier in the ALU.

---
 rtl/nonrestoring_div_32.sv | 135 +++++++++++++
 tb/tb_nonrestoring_div_32.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nonrestoring_div_32.sv
// Sequential signed divider: radix-2 non-restoring iteration on operand
// magnitudes, one quotient bit per clock, followed by a sign-fix cycle.
// Result packing: z = {remainder, quotient}; remainder takes the dividend's sign.
module nonrestoring_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic signed [WIDTH:0]   p;        // partial remainder, one guard bit for the sign
    logic [WIDTH-1:0]        q;        // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]        mag_b;
    logic                    sign_q;
    logic                    sign_r;
    logic [CNT_W-1:0]        count;

    logic signed [WIDTH:0]   b_ext;
    logic signed [WIDTH:0]   p_shift;
    logic signed [WIDTH:0]   p_step;
    logic signed [WIDTH:0]   p_fix;
    logic [WIDTH-1:0]        q_step;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is exact when read back as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Conditional negation modulo 2^WIDTH, used for the final sign fix.
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic            neg);
        return neg ? -v : v;
    endfunction

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    // One non-restoring step plus the final remainder correction.
    always_comb begin
        b_ext   = $signed({1'b0, mag_b});
        p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
        p_step  = p[WIDTH] ? (p_shift + b_ext) : (p_shift - b_ext);
        q_step  = {q[WIDTH-2:0], ~p_step[WIDTH]};
        p_fix   = p[WIDTH] ? (p + b_ext) : p;
    end

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: divide-by-zero skips straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CNT_W'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result load on entry to DONE.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            p           <= '0;
            q           <= '0;
            mag_b       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            count       <= '0;
            z           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q      <= magnitude(a);
                        mag_b  <= magnitude(b);
                        sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r <= a[WIDTH-1];
                        p      <= '0;
                        count  <= '0;
                        if (b == '0) begin
                            z           <= {a, {WIDTH{1'b1}}};
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    p     <= p_step;
                    q     <= q_step;
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    p <= p_fix;
                    z <= {cond_negate(p_fix[WIDTH-1:0], sign_r), cond_negate(q, sign_q)};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_div_32.sv
// Directed and random checks for the sequential signed divider.
module tb_nonrestoring_div_32;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    nonrestoring_div_32 #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .z           (z),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one divide, wait (bounded) for done, report result, latency and busy cycles.
    task automatic run_div(input logic [31:0] da, input logic [31:0] db,
                           output logic [63:0] rz, output logic rdbz,
                           output int lat, output int bcyc);
        @(negedge clock);
        a = da;
        b = db;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_0003;
        lat  = 0;
        bcyc = 0;
        while (!done && lat < 100) begin
            if (busy) bcyc++;
            @(posedge clock);
            #1;
            lat++;
        end
        rz   = z;
        rdbz = div_by_zero;
        check("done_seen", {63'd0, done}, 64'd1);
        @(posedge clock);
        #1;
        check("done_pulse", {63'd0, done}, 64'd0);
        check("z_hold", z, rz);
    endtask

    initial begin
        logic [63:0] rz;
        logic        rdbz;
        int          lat;
        int          bcyc;
        int          ndone;
        logic [63:0] z5;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sa;
        int          sb;
        int          qe;
        int          re;

        clear_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        #12;
        check("rst_z",    z, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
        @(negedge clock);
        clear_n = 1'b1;

        // 100 / 7
        run_div(32'd100, 32'd7, rz, rdbz, lat, bcyc);
        check("t1_z",    rz, 64'h00000002_0000000E);
        check("t1_dbz",  {63'd0, rdbz}, 64'd0);
        check("t1_lat",  64'(lat), 64'd33);
        check("t1_busy", 64'(bcyc), 64'd33);

        // signed combinations
        run_div(-32'sd100, 32'd7, rz, rdbz, lat, bcyc);
        check("t2_neg_a", rz, 64'hFFFFFFFE_FFFFFFF2);
        run_div(32'd100, -32'sd7, rz, rdbz, lat, bcyc);
        check("t2_neg_b", rz, 64'h00000002_FFFFFFF2);

        // divide by zero: done right after the accepting edge
        run_div(32'd7, 32'd0, rz, rdbz, lat, bcyc);
        check("t3_z",    rz, 64'h00000007_FFFFFFFF);
        check("t3_dbz",  {63'd0, rdbz}, 64'd1);
        check("t3_lat",  64'(lat), 64'd0);
        check("t3_busy", 64'(bcyc), 64'd0);
        check("t3_dbz_hold", {63'd0, div_by_zero}, 64'd1);

        // width corners
        run_div(32'h8000_0000, 32'hFFFF_FFFF, rz, rdbz, lat, bcyc);
        check("t4_min_m1", rz, 64'h00000000_80000000);
        check("t4_min_dbz", {63'd0, rdbz}, 64'd0);
        run_div(32'd0, 32'd5, rz, rdbz, lat, bcyc);
        check("t4_zero", rz, 64'd0);

        // start while busy is ignored
        @(negedge clock);
        a = 32'd12;
        b = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        ndone = 0;
        z5 = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                a = 32'd9;
                b = 32'd3;
                start = 1'b1;
            end
            if (c == 11) start = 1'b0;
            if (done) begin
                ndone++;
                z5 = z;
            end
            @(posedge clock);
            #1;
        end
        check("t5_ndone", 64'(ndone), 64'd1);
        check("t5_z", z5, 64'h00000002_00000002);
        check("t5_busy_idle", {63'd0, busy}, 64'd0);

        // asynchronous abort mid-operation
        @(negedge clock);
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #2;
        check("t6_busy_before", {63'd0, busy}, 64'd1);
        clear_n = 1'b0;
        #1;
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_done", {63'd0, done}, 64'd0);
        check("t6_z",    z, 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
        run_div(32'd100, 32'd7, rz, rdbz, lat, bcyc);
        check("t6_after", rz, 64'h00000002_0000000E);

        // random signed pairs against the language's truncating division
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = 32'($urandom_range(20)) - 32'd10;
            if (i % 5 == 0) ra = 32'($urandom_range(200)) - 32'd100;
            if (rb == 32'd0) rb = 32'd1;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            sa = ra;
            sb = rb;
            qe = sa / sb;
            re = sa % sb;
            run_div(ra, rb, rz, rdbz, lat, bcyc);
            check("rnd_z", rz, {re, qe});
            check("rnd_busy", 64'(bcyc), 64'd33);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
